// File: rtl/io_write_source_mux.sv
// Registered valid/ready mux routing one of four producer streams to the IO write port,
// selected by a per-session mode code. Optional beat counter: IO_MUX_BEAT_COUNT_EN.
module io_write_source_mux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_files,
  input  logic                    file_type,
  input  logic                    write_layer,
  input  logic [4*DATA_WIDTH-1:0] src_data,
  input  logic [3:0]              src_valid,
  output logic [3:0]              src_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_src,
  output logic                    busy,
  output logic                    err_illegal_sel
`ifdef IO_MUX_BEAT_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]    beat_count
`endif
);

  localparam int unsigned NUM_SRC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              code_q, code_d;
  logic [1:0]              sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [1:0]              osrc_q, osrc_d;
  logic                    err_q, err_d;

  logic [2:0]              code_c;
  logic                    code_legal_c;
  logic                    code_illegal_c;
  logic [1:0]              code_idx_c;
  logic [3:0]              ready_c;
  logic                    accept_c;
  logic                    start_c;
  logic [DATA_WIDTH-1:0]   src_word [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
    assign src_word[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Mode code decode: legal non-zero codes map to a source index
  always_comb begin
    code_c         = {write_files, file_type, write_layer};
    code_legal_c   = 1'b0;
    code_illegal_c = 1'b0;
    code_idx_c     = 2'd0;
    case (code_c)
      3'b001:  begin code_legal_c = 1'b1; code_idx_c = 2'd3; end
      3'b011:  begin code_legal_c = 1'b1; code_idx_c = 2'd2; end
      3'b100:  begin code_legal_c = 1'b1; code_idx_c = 2'd0; end
      3'b110:  begin code_legal_c = 1'b1; code_idx_c = 2'd1; end
      3'b000:  code_legal_c = 1'b0;
      default: code_illegal_c = 1'b1;
    endcase
  end

  // Next-state, handshake and output-register update
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    sel_d    = sel_q;
    data_d   = data_q;
    valid_d  = valid_q;
    osrc_d   = osrc_q;
    err_d    = 1'b0;
    ready_c  = 4'b0000;
    start_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (code_legal_c) begin
          state_d = ST_ACTIVE;
          code_d  = code_c;
          sel_d   = code_idx_c;
          start_c = 1'b1;
        end else if (code_illegal_c) begin
          err_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A mode change blocks acceptance in the same cycle it is seen
        if (code_c != code_q) begin
          state_d = ST_DRAIN;
        end else begin
          ready_c[sel_q] = !valid_q || out_ready;
        end
      end
      ST_DRAIN: begin
        if (!valid_q || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    accept_c = |(src_valid & ready_c);

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (accept_c) begin
      valid_d = 1'b1;
      data_d  = src_word[sel_q];
      osrc_d  = sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= 3'b000;
      sel_q   <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      osrc_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      osrc_q  <= osrc_d;
      err_q   <= err_d;
    end
  end

  assign src_ready       = ready_c;
  assign out_data        = data_q;
  assign out_valid       = valid_q;
  assign out_src         = osrc_q;
  assign busy            = (state_q != ST_IDLE);
  assign err_illegal_sel = err_q;

`ifdef IO_MUX_BEAT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Session beat counter: cleared on session start, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (start_c) begin
      cnt_d = '0;
    end else if (accept_c && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_count = cnt_q;
`else
  // CNT_WIDTH only sizes the optional counter; keep it referenced in this build
  logic [CNT_WIDTH-1:0] unused_cnt;
  logic                 unused_start;
  assign unused_cnt   = '0;
  assign unused_start = start_c;
`endif

endmodule

// File: tb/tb_io_write_source_mux.sv
// Bench for io_write_source_mux: directed vector table, hand sequences for drain and
// back-pressure, then random traffic checked against a beat-queue reference model.
module tb_io_write_source_mux;

  localparam int unsigned DW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  code;
  logic        write_files, file_type, write_layer;
  logic [31:0] src_data;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_src;
  logic        busy;
  logic        err_illegal_sel;
`ifdef IO_MUX_BEAT_COUNT_EN
  logic [1:0]  beat_count;
`endif

  assign {write_files, file_type, write_layer} = code;

  always #5 clk = ~clk;

  io_write_source_mux #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .write_files     (write_files),
    .file_type       (file_type),
    .write_layer     (write_layer),
    .src_data        (src_data),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_src         (out_src),
    .busy            (busy),
    .err_illegal_sel (err_illegal_sel)
`ifdef IO_MUX_BEAT_COUNT_EN
    ,
    .beat_count      (beat_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [2:0] c, input logic [3:0] v,
                       input logic [31:0] d, input logic o);
    rst_n = r; code = c; src_valid = v; src_data = d; out_ready = o;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [7:0] od,
                         input logic [1:0] os, input logic [3:0] sr, input logic bz,
                         input logic er);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(od));
    chk({tag, ".out_src"},   32'(out_src),   32'(os));
    chk({tag, ".src_ready"}, 32'(src_ready), 32'(sr));
    chk({tag, ".busy"},      32'(busy),      32'(bz));
    chk({tag, ".err"},       32'(err_illegal_sel), 32'(er));
  endtask

  task automatic go_idle();
    tick();
    drive(1'b1, 3'b000, 4'h0, 32'h0, 1'b1);
    repeat (3) tick();
    chk("go_idle.busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        r;
    logic [2:0]  c;
    logic [3:0]  v;
    logic [31:0] d;
    logic        o;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
    logic [3:0]  sr;
    logic        bz;
    logic        er;
  } vec_t;

  function automatic vec_t mk(logic [2:0] c, logic [3:0] v, logic [31:0] d, logic o,
                              logic ov, logic [7:0] od, logic [1:0] os, logic [3:0] sr,
                              logic bz, logic er);
    vec_t t;
    t.r = 1'b1; t.c = c; t.v = v; t.d = d; t.o = o;
    t.ov = ov; t.od = od; t.os = os; t.sr = sr; t.bz = bz; t.er = er;
    return t;
  endfunction

  // Reference model: spec code map, -1 for none/illegal
  function automatic int src_of(logic [2:0] c);
    case (c)
      3'b001:  return 3;
      3'b011:  return 2;
      3'b100:  return 0;
      3'b110:  return 1;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_illegal(logic [2:0] c);
    return (c == 3'b010) || (c == 3'b101) || (c == 3'b111);
  endfunction

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
  } beat_t;

  beat_t exp_q[$];
  bit    prev_idle;
  bit    prev_illegal;

  task automatic monitor();
    logic [3:0] hs;
    int         idx;
    beat_t      b;
    chk("rnd.sr_onehot", 32'($countones(src_ready) <= 1), 32'd1);
    if (!busy) chk("rnd.idle_quiet", 32'({out_valid, src_ready}), 32'd0);
    chk("rnd.err", 32'(err_illegal_sel), 32'(prev_idle && prev_illegal));
    prev_idle    = !busy;
    prev_illegal = is_illegal(code);
    hs  = src_valid & src_ready;
    idx = src_of(code);
    if (hs != 4'h0) begin
      chk("rnd.hs_src", 32'(hs), (idx >= 0) ? (32'd1 << idx) : 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          b.d = 8'((src_data >> (8 * i)) & 32'hFF);
          b.s = 2'(i);
          exp_q.push_back(b);
        end
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("rnd.spurious_beat", 32'd1, 32'd0);
      end else begin
        b = exp_q.pop_front();
        chk("rnd.out_data", 32'(out_data), 32'(b.d));
        chk("rnd.out_src",  32'(out_src),  32'(b.s));
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [2:0] legal_codes [4];
    int         hold;

    // Directed table: file-reader stream, mode exit, illegal code in IDLE
    vecs.push_back(mk(3'b110, 4'h0, 32'h0,         1, 0, 8'h00, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(3'b110, 4'hF, 32'hAABB11CC, 1, 0, 8'h00, 0, 4'b0010, 1, 0));
    vecs.push_back(mk(3'b110, 4'hF, 32'hAABB22CC, 1, 1, 8'h11, 1, 4'b0010, 1, 0));
    vecs.push_back(mk(3'b110, 4'hF, 32'hAABB33CC, 1, 1, 8'h22, 1, 4'b0010, 1, 0));
    vecs.push_back(mk(3'b110, 4'h0, 32'h0,         1, 1, 8'h33, 1, 4'b0010, 1, 0));
    vecs.push_back(mk(3'b000, 4'h0, 32'h0,         1, 0, 8'h33, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(3'b000, 4'h0, 32'h0,         1, 0, 8'h33, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(3'b000, 4'h0, 32'h0,         1, 0, 8'h33, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(3'b101, 4'hF, 32'h12345678, 1, 0, 8'h33, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(3'b101, 4'hF, 32'h12345678, 1, 0, 8'h33, 1, 4'b0000, 0, 1));
    vecs.push_back(mk(3'b101, 4'hF, 32'h12345678, 1, 0, 8'h33, 1, 4'b0000, 0, 1));
    vecs.push_back(mk(3'b000, 4'h0, 32'h0,         1, 0, 8'h33, 1, 4'b0000, 0, 1));
    vecs.push_back(mk(3'b000, 4'h0, 32'h0,         1, 0, 8'h33, 1, 4'b0000, 0, 0));

    // Reset with all sources asserting valid
    drive(1'b0, 3'b000, 4'hF, 32'hDEADBEEF, 1'b1);
    tick();
    tick();
    chk_all("reset", 0, 8'h00, 0, 4'b0000, 0, 0);

    foreach (vecs[k]) begin
      tick();
      drive(vecs[k].r, vecs[k].c, vecs[k].v, vecs[k].d, vecs[k].o);
      #1;
      chk_all($sformatf("vec%0d", k), vecs[k].ov, vecs[k].od, vecs[k].os, vecs[k].sr,
              vecs[k].bz, vecs[k].er);
    end

    // CNN stream with back-pressure: A5 must hold, then B6 follows exactly once
    tick();
    drive(1'b1, 3'b011, 4'h0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 3'b011, 4'b0100, 32'h00A50000, 1'b1);
    #1 chk("cnn.ready", 32'(src_ready), 32'b0100);
    tick();
    drive(1'b1, 3'b011, 4'b0100, 32'h00B60000, 1'b0);
    #1 chk_all("cnn.hold0", 1, 8'hA5, 2, 4'b0000, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("cnn.hold%0d", i + 1), 1, 8'hA5, 2, 4'b0000, 1, 0);
    end
    tick();
    out_ready = 1'b1;
    #1 chk_all("cnn.release", 1, 8'hA5, 2, 4'b0100, 1, 0);
    tick();
    drive(1'b1, 3'b011, 4'h0, 32'h0, 1'b1);
    #1 chk_all("cnn.next", 1, 8'hB6, 2, 4'b0100, 1, 0);
    tick();
    chk("cnn.empty", 32'(out_valid), 32'd0);
    go_idle();

    // Mode switch with a held beat: drain, back through IDLE, then layer source
    tick();
    drive(1'b1, 3'b100, 4'h0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 3'b100, 4'b1001, 32'h5C000077, 1'b0);
    #1 chk("sw.ready0", 32'(src_ready), 32'b0001);
    tick();
    code = 3'b001;
    #1 chk_all("sw.change", 1, 8'h77, 0, 4'b0000, 1, 0);
    tick();
    chk_all("sw.drain", 1, 8'h77, 0, 4'b0000, 1, 0);
    tick();
    out_ready = 1'b1;
    #1 chk_all("sw.drain_go", 1, 8'h77, 0, 4'b0000, 1, 0);
    tick();
    chk_all("sw.idle", 0, 8'h77, 0, 4'b0000, 0, 0);
    tick();
    chk_all("sw.active", 0, 8'h77, 0, 4'b1000, 1, 0);
    tick();
    src_valid = 4'h0;
    #1 chk_all("sw.layer", 1, 8'h5C, 3, 4'b1000, 1, 0);
    go_idle();

`ifdef IO_MUX_BEAT_COUNT_EN
    // Saturating session counter with CNT_WIDTH=2
    tick();
    drive(1'b1, 3'b110, 4'h0, 32'h0, 1'b1);
    tick();
    chk("bc.start", 32'(beat_count), 32'd0);
    src_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bc.beat%0d", i), 32'(beat_count), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    src_valid = 4'h0;
    go_idle();
    chk("bc.hold", 32'(beat_count), 32'd3);
    tick();
    drive(1'b1, 3'b001, 4'h0, 32'h0, 1'b1);
    tick();
    chk("bc.new_session", 32'(beat_count), 32'd0);
    src_valid = 4'b1000;
    tick();
    chk("bc.one", 32'(beat_count), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("bc.reset", 32'(beat_count), 32'd0);
    chk_all("bc.reset", 0, 8'h00, 0, 4'b0000, 0, 0);
`endif

    // Random traffic against the beat-queue model
    legal_codes[0] = 3'b001;
    legal_codes[1] = 3'b011;
    legal_codes[2] = 3'b100;
    legal_codes[3] = 3'b110;
    drive(1'b0, 3'b000, 4'h0, 32'h0, 1'b1);
    tick();
    tick();
    exp_q.delete();
    prev_idle    = 1'b1;
    prev_illegal = 1'b0;
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst_n = 1'b1;
      if (hold == 0) begin
        if ($urandom_range(0, 9) < 7) code = legal_codes[$urandom_range(0, 3)];
        else                          code = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 15);
      end
      hold--;
      src_valid = 4'($urandom);
      src_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1 monitor();
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      drive(1'b1, 3'b000, 4'h0, $urandom, 1'b1);
      #1 monitor();
    end
    chk("rnd.drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
